seven_seg_decoder: RTL and testbench

SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_pattern_lut.sv | 39 +++
 rtl/seven_seg_decoder.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment decoder.
// Patterns are active-low {g,f,e,d,c,b,a}, so bit0 is segment a.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational pattern lookup: a 7-bit segment pattern maps to its hex value.
// Any pattern outside the legal table, blank included, reports err with num = 0.
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       err,
  output logic [3:0] num
);

  // Pattern-to-value table
  always_comb begin
    err = 1'b0;
    num = 4'h0;
    case (pat)
      SEG_0:   num = 4'h0;
      SEG_1:   num = 4'h1;
      SEG_2:   num = 4'h2;
      SEG_3:   num = 4'h3;
      SEG_4:   num = 4'h4;
      SEG_5:   num = 4'h5;
      SEG_6:   num = 4'h6;
      SEG_7:   num = 4'h7;
      SEG_8:   num = 4'h8;
      SEG_9:   num = 4'h9;
      SEG_A:   num = 4'hA;
      SEG_B:   num = 4'hB;
      SEG_C:   num = 4'hC;
      SEG_D:   num = 4'hD;
      SEG_E:   num = 4'hE;
      SEG_F:   num = 4'hF;
      default: begin
        err = 1'b1;
        num = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_decoder.sv
// Debounced seven-segment bus decoder: a pattern must hold for STABLE_CYCLES
// synchronized cycles before it is reported once over a valid/ready handshake.
module seven_seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_num,
  output logic       out_err,
  output logic       ovr,
  input  logic       ovr_clr
);

  localparam int CW = $clog2(STABLE_CYCLES + 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);
  localparam logic [CW-1:0] CNT_QUAL = CW'(STABLE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);

  logic [6:0]    sync1_r, seg_s;
  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [6:0]    cand_r, cand_nxt_s;
  logic [6:0]    last_rep_r, last_rep_nxt_s;
  logic          out_valid_r, out_valid_nxt_s;
  logic [3:0]    out_num_r, out_num_nxt_s;
  logic          out_err_r, out_err_nxt_s;
  logic          ovr_r, ovr_event_s;
  logic          qualify_s;
  logic          lut_err_s;
  logic [3:0]    lut_num_s;

  seg_pattern_lut u_lut (
    .pat (cand_r),
    .err (lut_err_s),
    .num (lut_num_s)
  );

  // Two-flop synchronizer for the asynchronous segment bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= SEG_BLANK;
      seg_s   <= SEG_BLANK;
    end else begin
      sync1_r <= seg_in;
      seg_s   <= sync1_r;
    end
  end

  // Next-state, stability filter and handshake decisions
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    cand_nxt_s      = cand_r;
    last_rep_nxt_s  = last_rep_r;
    out_valid_nxt_s = out_valid_r;
    out_num_nxt_s   = out_num_r;
    out_err_nxt_s   = out_err_r;
    ovr_event_s     = 1'b0;
    qualify_s       = (seg_s == cand_r) && (cnt_r == CNT_QUAL);

    // Filtering keeps running in PRESENT so a second symbol can be flagged as overrun
    if (state_r != ST_IDLE) begin
      if (seg_s != cand_r) begin
        cand_nxt_s = seg_s;
        cnt_nxt_s  = CNT_ONE;
      end else if (cnt_r != CNT_SAT) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (seg_s != last_rep_r) begin
          cnt_nxt_s   = CNT_ONE;
          cand_nxt_s  = seg_s;
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!qualify_s) begin
          state_nxt_s = ST_SETTLE;
        end else if (cand_r == last_rep_r) begin
          state_nxt_s = ST_IDLE;
        end else if (cand_r == SEG_BLANK) begin
          last_rep_nxt_s = SEG_BLANK;
          state_nxt_s    = ST_IDLE;
        end else begin
          last_rep_nxt_s  = cand_r;
          out_num_nxt_s   = lut_num_s;
          out_err_nxt_s   = lut_err_s;
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (qualify_s && (cand_r != last_rep_r)) begin
          ovr_event_s = 1'b1;
        end else begin
          ovr_event_s = 1'b0;
        end
        if (out_valid_r && out_ready) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_PRESENT;
        end
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // State, filter and output registers; an overrun event beats ovr_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      cand_r      <= SEG_BLANK;
      last_rep_r  <= SEG_BLANK;
      out_valid_r <= 1'b0;
      out_num_r   <= 4'h0;
      out_err_r   <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      cand_r      <= cand_nxt_s;
      last_rep_r  <= last_rep_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_num_r   <= out_num_nxt_s;
      out_err_r   <= out_err_nxt_s;
      if (ovr_event_s) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_num   = out_num_r;
  assign out_err   = out_err_r;
  assign ovr       = ovr_r;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: a run-length reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_seven_seg_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'b1111111;
  logic       out_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       out_valid, out_err, ovr;
  logic [3:0] out_num;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [6:0] pat_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seven_seg_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_err   (out_err),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {err, num}: table index of the pattern, or err with 0 when absent
  function automatic logic [4:0] model_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (pat_tbl[i] == p) return {1'b0, 4'(i)};
    end
    return 5'h10;
  endfunction

  // Reference model: a pattern qualifies when the synchronized bus has shown it
  // for STABLE consecutive cycles; an acceptance restarts the observation.
  logic [6:0] m_s1, m_s2, m_run_val, m_last;
  int         m_run;
  logic       m_valid, m_err, m_ovr;
  logic [3:0] m_num;
  int         t_run;
  logic [6:0] t_rv, t_last;
  logic       t_valid, t_err, t_ovr_ev;
  logic [3:0] t_num;
  logic [4:0] t_dec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= BLANK; m_s2 <= BLANK; m_run_val <= BLANK; m_last <= BLANK;
      m_run <= 0; m_valid <= 1'b0; m_err <= 1'b0; m_num <= 4'h0; m_ovr <= 1'b0;
    end else begin
      t_run = m_run; t_rv = m_run_val; t_last = m_last;
      t_valid = m_valid; t_err = m_err; t_num = m_num; t_ovr_ev = 1'b0;
      if (t_run > 0 && m_s2 == t_rv) t_run = t_run + 1;
      else begin t_rv = m_s2; t_run = 1; end
      if (t_run == STABLE) begin
        if (m_valid) t_ovr_ev = (t_rv != t_last);
        else if (t_rv != t_last) begin
          t_last = t_rv;
          if (t_rv != BLANK) begin
            t_dec = model_decode(t_rv);
            t_valid = 1'b1; t_err = t_dec[4]; t_num = t_dec[3:0];
          end
        end
      end
      if (m_valid && out_ready) begin t_valid = 1'b0; t_run = 0; end
      m_s1 <= seg_in; m_s2 <= m_s1;
      m_run <= t_run; m_run_val <= t_rv; m_last <= t_last;
      m_valid <= t_valid; m_err <= t_err; m_num <= t_num;
      m_ovr <= t_ovr_ev | (m_ovr & ~ovr_clr);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_valid", out_valid, m_valid);
      check("cyc_ovr", ovr, m_ovr);
      if (m_valid || !rst_n) begin
        check("cyc_num", out_num, m_num);
        check("cyc_err", out_err, m_err);
      end
    end
  end

  // Log of accepted symbols {err, num}
  logic [4:0] rep_q [$];
  always @(posedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      rep_q.push_back({out_err, out_num});
  end

  task automatic wait_valid(input string nm, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    check({nm, "_timeout"}, seen, 1);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int hold_n;
    int sel;

    // Literal pins on the model's table
    check("model_dec_b", model_decode(7'b0000011), 5'h0B);
    check("model_dec_illegal", model_decode(7'b1010101), 5'h10);
    check("model_dec_blank", model_decode(7'b1111111), 5'h10);

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_num", out_num, 0);
    check("rst_err", out_err, 0);
    check("rst_ovr", ovr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Latency of a clean edge to digit 3
    out_ready = 1'b1;
    seg_in = 7'b0110000;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = i; break; end
    end
    check("t1_latency", lat, 6);
    check("t1_num", out_num, 4'h3);
    check("t1_err", out_err, 0);
    @(negedge clk);
    check("t1_one_cycle", out_valid, 0);

    // Bouncing 9/A settles on A only
    rep_q.delete();
    for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? 7'b0010000 : 7'b0001000, 2);
    hold(7'b0001000, 14);
    check("t2_count", rep_q.size(), 1);
    if (rep_q.size() == 1) check("t2_val", rep_q[0], 5'h0A);

    // Illegal pattern reported once as error
    rep_q.delete();
    hold(7'b1010101, 25);
    check("t3_count", rep_q.size(), 1);
    if (rep_q.size() == 1) check("t3_val", rep_q[0], 5'h10);

    // Overrun while 5 is waiting for acceptance
    out_ready = 1'b0;
    rep_q.delete();
    seg_in = 7'b0010010;
    wait_valid("t4_five", 15);
    hold(7'b0000010, 12);
    check("t4_valid_held", out_valid, 1);
    check("t4_num_held", out_num, 4'h5);
    check("t4_ovr_set", ovr, 1);
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    check("t4_count", rep_q.size(), 2);
    if (rep_q.size() == 2) begin
      check("t4_first", rep_q[0], 5'h05);
      check("t4_second", rep_q[1], 5'h06);
    end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("t4_ovr_clr", ovr, 0);

    // Reset while presenting 8
    out_ready = 1'b0;
    seg_in = 7'b0000000;
    wait_valid("t5_eight", 15);
    check("t5_num", out_num, 4'h8);
    #2 rst_n = 1'b0;
    #1 check("t5_async_clear", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("t5_again", 20);
    check("t5_num_again", out_num, 4'h8);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // 7, blank, 7 gives two reports
    rep_q.delete();
    hold(7'b1111000, 10);
    hold(BLANK, 10);
    hold(7'b1111000, 10);
    repeat (8) @(negedge clk);
    check("t6_count", rep_q.size(), 2);
    if (rep_q.size() == 2) begin
      check("t6_first", rep_q[0], 5'h07);
      check("t6_second", rep_q[1], 5'h07);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; ) begin
      sel = $urandom_range(0, 19);
      if (sel < 16) seg_in = pat_tbl[sel];
      else if (sel == 16) seg_in = BLANK;
      else seg_in = 7'($urandom);
      hold_n = $urandom_range(1, 7);
      for (int h = 0; h < hold_n; h++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ovr_clr = ($urandom_range(0, 9) == 0);
        @(negedge clk);
        c++;
      end
    end
    ovr_clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
